axi4_rd_to_wide_axis: RTL and testbench
=======================================

# axi4_rd_to_wide_axis

Single-clock AXI4 read master that fetches a contiguous region of `total_len` beats starting at `addr` and presents it as one AXI-stream packet. Requests are split into INCR bursts of at most `max_length` beats, each with an incrementing ID. The block sits on the memory-read side of a datapath, mirroring the stream-to-AXI4 write path. One burst is outstanding at a time, and a 2-entry skid buffer decouples R from the stream output.

## Interface
- `DSIZE`, 128: data width in bits, a power of two ≥ 8.
- `IDSIZE`, 4: AXI ID width.
- `ASIZE`, 32: AXI address width.
- `LSIZE`, 8: AXI length field width.
- `ADDR_STEP`, 1: address units advanced per beat.

- `axi_aclk` in 1: clock.
- `axi_aresetn` in 1: asynchronous, active-low reset.
- `start` in 1: request pulse, sampled only in IDLE.
- `addr` in 32: start address, latched on accepted `start`.
- `total_len` in 32: beats to read, latched on accepted `start`.
- `max_length` in 32: burst cap, latched on accepted `start`.
- `busy` out 1: high from accepted `start` until `done`.
- `done` out 1: one-cycle pulse when the last stream beat is accepted.
- `err` out 1: sticky; set on RRESP≠0 or an RLAST mismatch; cleared on the next accepted `start`.
- `axi_arid` out IDSIZE: burst ID.
- `axi_araddr` out ASIZE: burst address.
- `axi_arlen` out LSIZE: beats−1.
- `axi_arsize` out 3: constant log2(DSIZE/8).
- `axi_arburst` out 2: constant 2'b01 (INCR).
- `axi_arvalid` out 1, `axi_arready` in 1: AR handshake.
- `axi_rid` in IDSIZE: ignored.
- `axi_rdata` in DSIZE: read data.
- `axi_rresp` in 2: read response.
- `axi_rlast` in 1: last beat of burst.
- `axi_rvalid` in 1, `axi_rready` out 1: R handshake.
- `axis_tdata` out DSIZE: stream data.
- `axis_tkeep` out DSIZE/8: all ones.
- `axis_tlast` out 1: high on the final beat of `total_len`.
- `axis_tvalid` out 1, `axis_tready` in 1: stream handshake.

## Operation
- **Effective burst cap:** `cap` = clamp(`max_length`, 1, 2**LSIZE). `max_length`=0 is treated as 1.
- **FSM states:** IDLE, AR, DATA, DRAIN.
- **IDLE:**
  - On `start` with `total_len`≠0: latch inputs, clear `err`, set `busy`, go to AR.
  - On `start` with `total_len`=0: pulse `done` next cycle, issue no AR, leave `busy` low.
- **AR:**
  - `axi_arvalid`=1.
  - `beats` = min(`remaining`, `cap`); `axi_arlen` = `beats`−1.
  - ARADDR/ARLEN/ARID are held stable while ARVALID is high.
  - On the handshake: `cur_addr` += `beats`·ADDR_STEP (wraps modulo 2^ASIZE), `remaining` −= `beats`, ID += 1 (wraps), go to DATA.
- **DATA:**
  - Count accepted R beats against `beats`.
  - The beat counter is authoritative for ending a burst. RLAST asserted early, or missing on the counted final beat, sets `err`.
  - Any RRESP≠0 sets `err`; the data is still forwarded.
  - On the final counted beat: go to AR if `remaining`≠0, otherwise to DRAIN.
- **DRAIN:** wait until the skid buffer empties, then pulse `done`, drop `busy`, go to IDLE.
- **Stream tagging:** a global beat counter tags the beat with index `total_len`−1 as `axis_tlast`.
- **Skid buffer:**
  - 2 entries; `axi_rready` = DATA state && buffer not full.
  - Stream order equals R order; no beat is lost or duplicated under any backpressure.
- `start` is ignored while `busy`.

## Timing
- **Reset values:** all outputs 0 except `axis_tkeep` (all ones) and the constant `axi_arsize`/`axi_arburst`. Internal ID=0, state IDLE.
- **Reset mid-operation:**
  - Immediate return to IDLE with the buffer emptied.
  - No further AR is issued; in-flight R beats after reset are not accepted until the next request.
- **Start to AR:** accepted `start` at cycle N → `axi_arvalid` high at cycle N+1.
- **R to stream:** an R handshake at cycle N → the beat is visible on `axis_tvalid` at N+1 at the earliest (registered output).
- **Full buffer:** with a full buffer and `axis_tready`=1, one entry frees per cycle and `axi_rready` rises the following cycle.
- **Next burst:** the next AR issues the cycle after the final R handshake of the prior burst. The gap is one cycle; there is no overlap.
- **Done:** `done` fires the cycle after the `axis_tlast` handshake.

## Test plan
- `addr`=0x1000, `total_len`=4, `max_length`=16, responder always ready, `axis_tready`=1 → one AR (ARLEN=3, ID=0); 4 beats out with tlast on beat 3; `done` pulses.
- `total_len`=37, `max_length`=16, ADDR_STEP=16 → ARs at 0x1000/0x1100/0x1200 with ARLEN 15/15/4 and IDs 0/1/2; 37 beats in order; a single tlast.
- Random `axis_tready` (30% high) with R always valid → no beat lost or duplicated; `axi_rready` never high while the buffer is full.
- Responder returns RRESP=2'b10 on beat 2, and in a separate run RLAST early on beat 1 of a 4-beat burst → `err`=1; transfer completes with 4 beats; `err` clears on the next `start`.
- `total_len`=0 → no AR, `done` at N+1; `max_length`=0 with `total_len`=3 → three ARs with ARLEN=0.
- Assert `axi_aresetn` low mid-burst with the buffer holding 2 beats → all outputs return to reset values; a new request afterwards starts with ID=0 and completes correctly.

Source files
------------

// File: rtl/axi4_rd_to_wide_axis.sv
// AXI4 read master that fetches a contiguous region as a series of INCR
// bursts (one outstanding) and replays the data as a single AXI-stream
// packet through a 2-entry skid buffer.
module axi4_rd_to_wide_axis #(
    parameter int DSIZE     = 128,
    parameter int IDSIZE    = 4,
    parameter int ASIZE     = 32,
    parameter int LSIZE     = 8,
    parameter int ADDR_STEP = 1
) (
    input  logic                 axi_aclk,
    input  logic                 axi_aresetn,
    // request side
    input  logic                 start,
    input  logic [31:0]          addr,
    input  logic [31:0]          total_len,
    input  logic [31:0]          max_length,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    // AXI4 read address channel
    output logic [IDSIZE-1:0]    axi_arid,
    output logic [ASIZE-1:0]     axi_araddr,
    output logic [LSIZE-1:0]     axi_arlen,
    output logic [2:0]           axi_arsize,
    output logic [1:0]           axi_arburst,
    output logic                 axi_arvalid,
    input  logic                 axi_arready,
    // AXI4 read data channel
    input  logic [IDSIZE-1:0]    axi_rid,
    input  logic [DSIZE-1:0]     axi_rdata,
    input  logic [1:0]           axi_rresp,
    input  logic                 axi_rlast,
    input  logic                 axi_rvalid,
    output logic                 axi_rready,
    // AXI-stream output
    output logic [DSIZE-1:0]     axis_tdata,
    output logic [DSIZE/8-1:0]   axis_tkeep,
    output logic                 axis_tlast,
    output logic                 axis_tvalid,
    input  logic                 axis_tready
);

    localparam logic [2:0]  AR_SIZE   = 3'($clog2(DSIZE / 8));
    localparam logic [31:0] MAX_BURST = 32'd1 << LSIZE;

    typedef enum logic [1:0] {
        S_IDLE,
        S_AR,
        S_DATA,
        S_DRAIN
    } state_e;

    // max_length of 0 behaves as 1; anything above the ARLEN range is capped
    function automatic logic [31:0] clamp_cap(input logic [31:0] m);
        if (m == 32'd0) begin
            return 32'd1;
        end else if (m > MAX_BURST) begin
            return MAX_BURST;
        end
        return m;
    endfunction

    function automatic logic [31:0] min_u32(input logic [31:0] a, input logic [31:0] b);
        return (a < b) ? a : b;
    endfunction

    // FSM / address generator state
    state_e             state_q;
    logic [ASIZE-1:0]   cur_addr_q;
    logic [31:0]        remaining_q;
    logic [31:0]        total_len_q;
    logic [31:0]        cap_q;
    logic [31:0]        beats_q;
    logic [31:0]        beat_cnt_q;
    logic [31:0]        out_cnt_q;
    logic [IDSIZE-1:0]  id_q;
    logic [LSIZE-1:0]   arlen_q;
    logic               arvalid_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;

    // skid buffer state
    logic [DSIZE-1:0]   buf_data_q [2];
    logic [1:0]         buf_last_q;
    logic               wr_ptr_q;
    logic               rd_ptr_q;
    logic [1:0]         count_q;

    // combinational helpers
    logic [31:0]        cap_d;
    logic [31:0]        first_beats_d;
    logic [31:0]        next_beats_d;
    logic               last_beat_d;
    logic               push_last_d;
    logic               r_fire;
    logic               s_fire;
    logic               unused_rid;

    assign cap_d         = clamp_cap(max_length);
    assign first_beats_d = min_u32(total_len, cap_d);
    assign next_beats_d  = min_u32(remaining_q, cap_q);
    assign last_beat_d   = (beat_cnt_q == beats_q - 32'd1);
    assign push_last_d   = (out_cnt_q == total_len_q - 32'd1);

    assign axi_rready = (state_q == S_DATA) && (count_q != 2'd2);
    assign r_fire     = axi_rvalid && axi_rready;
    assign s_fire     = axis_tvalid && axis_tready;

    // RID carries no information for a single-outstanding master
    assign unused_rid = ^axi_rid;

    assign axi_arid    = id_q;
    assign axi_araddr  = cur_addr_q;
    assign axi_arlen   = arlen_q;
    assign axi_arsize  = AR_SIZE;
    assign axi_arburst = 2'b01;
    assign axi_arvalid = arvalid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

    assign axis_tvalid = (count_q != 2'd0);
    assign axis_tdata  = buf_data_q[rd_ptr_q];
    assign axis_tlast  = buf_last_q[rd_ptr_q];
    assign axis_tkeep  = '1;

    // Control FSM: burst splitting, R beat counting, error capture, done/busy
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q     <= S_IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            total_len_q <= '0;
            cap_q       <= '0;
            beats_q     <= '0;
            beat_cnt_q  <= '0;
            out_cnt_q   <= '0;
            id_q        <= '0;
            arlen_q     <= '0;
            arvalid_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register here samples
            // pre-edge values regardless of statement order.
            done_q <= 1'b0;
            if (r_fire) begin
                out_cnt_q <= out_cnt_q + 32'd1;
            end
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        err_q <= 1'b0;
                        if (total_len != 32'd0) begin
                            cur_addr_q  <= ASIZE'(addr);
                            remaining_q <= total_len;
                            total_len_q <= total_len;
                            cap_q       <= cap_d;
                            beats_q     <= first_beats_d;
                            arlen_q     <= LSIZE'(first_beats_d - 32'd1);
                            out_cnt_q   <= '0;
                            arvalid_q   <= 1'b1;
                            busy_q      <= 1'b1;
                            state_q     <= S_AR;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                S_AR: begin
                    if (axi_arready) begin
                        arvalid_q   <= 1'b0;
                        cur_addr_q  <= cur_addr_q + ASIZE'(beats_q * ADDR_STEP);
                        remaining_q <= remaining_q - beats_q;
                        id_q        <= id_q + 1'b1;
                        beat_cnt_q  <= '0;
                        state_q     <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (r_fire) begin
                        if (axi_rresp != 2'b00) begin
                            err_q <= 1'b1;
                        end
                        // the counter, not RLAST, decides where the burst ends
                        if (axi_rlast != last_beat_d) begin
                            err_q <= 1'b1;
                        end
                        if (last_beat_d) begin
                            if (remaining_q != 32'd0) begin
                                beats_q   <= next_beats_d;
                                arlen_q   <= LSIZE'(next_beats_d - 32'd1);
                                arvalid_q <= 1'b1;
                                state_q   <= S_AR;
                            end else begin
                                state_q <= S_DRAIN;
                            end
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 32'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    // finish in the same edge that pops the final entry
                    if ((count_q == 2'd0) || ((count_q == 2'd1) && s_fire)) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Two-entry skid buffer between R and the stream output
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            // NOTE: the data entries are reset too, because tdata drives a port
            // straight from storage and must read zero out of reset.
            for (int i = 0; i < 2; i++) begin
                buf_data_q[i] <= '0;
            end
            buf_last_q <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            if (r_fire) begin
                buf_data_q[wr_ptr_q] <= axi_rdata;
                buf_last_q[wr_ptr_q] <= push_last_d;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (s_fire) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            if (r_fire && !s_fire) begin
                count_q <= count_q + 2'd1;
            end else if (!r_fire && s_fire) begin
                count_q <= count_q - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_axi4_rd_to_wide_axis.sv
// Self-checking bench: table of transfers driven through an AXI read
// responder and a stream sink, with AR and beat scoreboards, plus hand
// sequences for zero length and reset with a full skid buffer.
module tb_axi4_rd_to_wide_axis;

    localparam int DSIZE  = 128;
    localparam int IDSIZE = 4;
    localparam int ASIZE  = 32;
    localparam int LSIZE  = 8;
    localparam int STEP   = 16;

    logic                axi_aclk = 1'b0;
    logic                axi_aresetn;
    logic                start;
    logic [31:0]         addr;
    logic [31:0]         total_len;
    logic [31:0]         max_length;
    logic                busy;
    logic                done;
    logic                err;
    logic [IDSIZE-1:0]   axi_arid;
    logic [ASIZE-1:0]    axi_araddr;
    logic [LSIZE-1:0]    axi_arlen;
    logic [2:0]          axi_arsize;
    logic [1:0]          axi_arburst;
    logic                axi_arvalid;
    logic                axi_arready;
    logic [IDSIZE-1:0]   axi_rid;
    logic [DSIZE-1:0]    axi_rdata;
    logic [1:0]          axi_rresp;
    logic                axi_rlast;
    logic                axi_rvalid;
    logic                axi_rready;
    logic [DSIZE-1:0]    axis_tdata;
    logic [DSIZE/8-1:0]  axis_tkeep;
    logic                axis_tlast;
    logic                axis_tvalid;
    logic                axis_tready;

    axi4_rd_to_wide_axis #(
        .DSIZE(DSIZE), .IDSIZE(IDSIZE), .ASIZE(ASIZE), .LSIZE(LSIZE), .ADDR_STEP(STEP)
    ) dut (
        .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
        .start(start), .addr(addr), .total_len(total_len), .max_length(max_length),
        .busy(busy), .done(done), .err(err),
        .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
        .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
        .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .axis_tdata(axis_tdata), .axis_tkeep(axis_tkeep), .axis_tlast(axis_tlast),
        .axis_tvalid(axis_tvalid), .axis_tready(axis_tready)
    );

    always #5 axi_aclk = ~axi_aclk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] len;
        logic [31:0] maxl;
        int          tready_pct;
        int          rgap_pct;
        int          arready_pct;
        int          err_mode;     // 0 none, 1 RRESP on beat 2, 2 RLAST on beat 1
        int          exp_nars;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [3:0]  id;
    } ar_t;

    typedef struct {
        logic [127:0] data;
        logic         last;
    } beat_t;

    vec_t  vecs [10];
    ar_t   exp_ar_q [$];
    beat_t exp_beat_q [$];

    int total_checks = 0;
    int bad_checks   = 0;

    int cyc = 0;
    int occ, occ_err, stab_err, gap_err;
    int ar_count, done_cnt, done_cyc, tlast_cyc, first_ar_cyc;
    logic [3:0] exp_id;
    bit gap_pend, gap_expect_ar;
    bit prev_ar_wait;
    logic [31:0] prev_araddr;
    logic [7:0]  prev_arlen;
    logic [3:0]  prev_arid;
    bit r_active, r_hold;
    logic [31:0] r_base;
    int r_beats, r_idx;
    int err_mode, tready_pct, rgap_pct, arready_pct;

    function automatic logic [127:0] pat(input logic [31:0] a);
        return {a, ~a, a ^ 32'h5A5A_5A5A, a + 32'h1234_5678};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total_checks++;
        if (act !== exp) begin
            bad_checks++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // One clock: observe outputs at the falling edge, then drive responder/sink
    task automatic step();
        beat_t eb;
        ar_t   ea;
        @(negedge axi_aclk);
        cyc++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (gap_pend) begin
            if (axi_arvalid != gap_expect_ar) gap_err++;
            gap_pend = 0;
        end
        if (prev_ar_wait && (!axi_arvalid || axi_araddr != prev_araddr ||
                             axi_arlen != prev_arlen || axi_arid != prev_arid)) stab_err++;
        if (axi_arvalid && first_ar_cyc < 0) first_ar_cyc = cyc;
        if (occ == 2 && axi_rready) occ_err++;
        // stream sink
        axis_tready = (int'($urandom_range(0, 99)) < tready_pct);
        if (axis_tvalid && axis_tready) begin
            if (exp_beat_q.size() == 0) begin
                total_checks++;
                bad_checks++;
                $display("FAIL extra_beat: got data 0x%0h, want no beat", axis_tdata);
            end else begin
                eb = exp_beat_q.pop_front();
                check("beat_data", axis_tdata, eb.data);
                check("beat_last", axis_tlast, eb.last);
            end
            occ--;
            if (axis_tlast) tlast_cyc = cyc;
        end
        // R responder
        if (r_active) begin
            if (!r_hold) axi_rvalid = (int'($urandom_range(0, 99)) >= rgap_pct);
            axi_rdata = pat(r_base + 32'(r_idx) * 32'(STEP));
            axi_rresp = (err_mode == 1 && r_idx == 2) ? 2'b10 : 2'b00;
            axi_rlast = (err_mode == 2) ? (r_idx == 1) : (r_idx == r_beats - 1);
            r_hold = axi_rvalid && !axi_rready;
            if (axi_rvalid && axi_rready) begin
                occ++;
                r_idx++;
                if (r_idx == r_beats) begin
                    r_active = 0;
                    gap_pend = 1;
                    gap_expect_ar = (exp_ar_q.size() != 0);
                end
            end
        end else begin
            axi_rvalid = 1'b0;
            axi_rlast  = 1'b0;
            r_hold     = 0;
        end
        // AR responder
        axi_arready = (int'($urandom_range(0, 99)) < arready_pct);
        prev_ar_wait = axi_arvalid && !axi_arready;
        prev_araddr  = axi_araddr;
        prev_arlen   = axi_arlen;
        prev_arid    = axi_arid;
        if (axi_arvalid && axi_arready) begin
            ar_count++;
            if (exp_ar_q.size() == 0) begin
                total_checks++;
                bad_checks++;
                $display("FAIL extra_ar: got addr 0x%0h, want no AR", axi_araddr);
            end else begin
                ea = exp_ar_q.pop_front();
                check("ar_addr", axi_araddr, ea.addr);
                check("ar_len", axi_arlen, ea.len);
                check("ar_id", axi_arid, ea.id);
            end
            r_active = 1;
            r_base   = axi_araddr;
            r_beats  = int'(axi_arlen) + 1;
            r_idx    = 0;
        end
    endtask

    // Fill the AR and beat scoreboards for one transfer and set responder knobs
    task automatic load_model(input vec_t v);
        logic [31:0] rem, a, cap, nb;
        ar_t   ea;
        beat_t eb;
        cap = (v.maxl == 32'd0) ? 32'd1 : ((v.maxl > 32'd256) ? 32'd256 : v.maxl);
        rem = v.len;
        a   = v.addr;
        while (rem != 32'd0) begin
            nb      = (rem < cap) ? rem : cap;
            ea.addr = a;
            ea.len  = 8'(nb - 32'd1);
            ea.id   = exp_id;
            exp_ar_q.push_back(ea);
            a      = a + nb * 32'(STEP);
            rem    = rem - nb;
            exp_id = exp_id + 4'd1;
        end
        for (int k = 0; k < int'(v.len); k++) begin
            eb.data = pat(v.addr + 32'(k) * 32'(STEP));
            eb.last = (k == int'(v.len) - 1);
            exp_beat_q.push_back(eb);
        end
        tready_pct  = v.tready_pct;
        rgap_pct    = v.rgap_pct;
        arready_pct = v.arready_pct;
        err_mode    = v.err_mode;
        occ_err = 0; stab_err = 0; gap_err = 0;
        ar_count = 0; done_cnt = 0; done_cyc = -1; tlast_cyc = -1; first_ar_cyc = -1;
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        int   start_cyc;
        int   n;
        string t;
        v = vecs[idx];
        t = $sformatf("v%0d", idx);
        load_model(v);
        start      = 1'b1;
        addr       = v.addr;
        total_len  = v.len;
        max_length = v.maxl;
        start_cyc  = cyc;
        step();
        start = 1'b0;
        check({t, "_busy"}, busy, 1'b1);
        check({t, "_err_clr"}, err, 1'b0);
        n = 0;
        while (done_cnt == 0 && n < 6000) begin
            step();
            n++;
        end
        check({t, "_done_seen"}, done_cnt != 0, 1'b1);
        check({t, "_ar_at_n1"}, first_ar_cyc, start_cyc + 1);
        check({t, "_done_after_tlast"}, done_cyc, tlast_cyc + 1);
        check({t, "_n_ars"}, ar_count, v.exp_nars);
        check({t, "_ars_left"}, exp_ar_q.size(), 0);
        check({t, "_beats_left"}, exp_beat_q.size(), 0);
        check({t, "_err"}, err, v.exp_err);
        check({t, "_busy_end"}, busy, 1'b0);
        check({t, "_rready_full"}, occ_err, 0);
        check({t, "_ar_stable"}, stab_err, 0);
        check({t, "_ar_gap"}, gap_err, 0);
        step();
        step();
        check({t, "_done_pulse"}, done_cnt, 1);
    endtask

    task automatic check_reset(input string t);
        check({t, "_busy"}, busy, 1'b0);
        check({t, "_done"}, done, 1'b0);
        check({t, "_err"}, err, 1'b0);
        check({t, "_arvalid"}, axi_arvalid, 1'b0);
        check({t, "_araddr"}, axi_araddr, 32'h0);
        check({t, "_arlen"}, axi_arlen, 8'h0);
        check({t, "_arid"}, axi_arid, 4'h0);
        check({t, "_arsize"}, axi_arsize, 3'd4);
        check({t, "_arburst"}, axi_arburst, 2'b01);
        check({t, "_rready"}, axi_rready, 1'b0);
        check({t, "_tvalid"}, axis_tvalid, 1'b0);
        check({t, "_tlast"}, axis_tlast, 1'b0);
        check({t, "_tdata"}, axis_tdata, 128'h0);
        check({t, "_tkeep"}, axis_tkeep, 16'hFFFF);
    endtask

    initial begin
        int s;
        int n;
        int stale_rdy;
        //          addr           len      maxl    trdy rgap ardy err nars err
        vecs[0] = '{32'h0000_1000, 32'd4,   32'd16,   100,  0, 100, 0, 1, 1'b0};
        vecs[1] = '{32'h0000_1000, 32'd37,  32'd16,   100,  0, 100, 0, 3, 1'b0};
        vecs[2] = '{32'h0000_2000, 32'd50,  32'd8,     30,  0, 100, 0, 7, 1'b0};
        vecs[3] = '{32'h0000_3000, 32'd4,   32'd16,   100,  0, 100, 1, 1, 1'b1};
        vecs[4] = '{32'h0000_4000, 32'd4,   32'd16,   100,  0, 100, 2, 1, 1'b1};
        vecs[5] = '{32'h0000_5000, 32'd3,   32'd0,    100,  0, 100, 0, 3, 1'b0};
        vecs[6] = '{32'hFFFF_FFE0, 32'd5,   32'd2,     70, 20,  60, 0, 3, 1'b0};
        vecs[7] = '{32'h0000_6000, 32'd300, 32'd1000, 100,  0, 100, 0, 2, 1'b0};
        vecs[8] = '{32'h0000_7000, 32'd20,  32'd7,     50, 40,  50, 0, 3, 1'b0};
        vecs[9] = '{32'h0000_A000, 32'd6,   32'd4,    100,  0, 100, 0, 2, 1'b0};

        axi_aresetn = 1'b0;
        start = 1'b0; addr = '0; total_len = '0; max_length = '0;
        axi_arready = 1'b0; axi_rid = '0; axi_rdata = '0; axi_rresp = '0;
        axi_rlast = 1'b0; axi_rvalid = 1'b0; axis_tready = 1'b0;
        occ = 0; exp_id = 4'd0; gap_pend = 0; prev_ar_wait = 0;
        r_active = 0; r_hold = 0; r_base = '0; r_beats = 0; r_idx = 0;
        err_mode = 0; tready_pct = 100; rgap_pct = 0; arready_pct = 100;
        occ_err = 0; stab_err = 0; gap_err = 0;
        ar_count = 0; done_cnt = 0; done_cyc = -1; tlast_cyc = -1; first_ar_cyc = -1;

        repeat (2) @(negedge axi_aclk);
        check_reset("por");
        axi_aresetn = 1'b1;
        repeat (2) step();

        for (int i = 0; i < 9; i++) begin
            run_vec(i);
        end

        // zero-length request: done next cycle, no AR, busy stays low
        ar_count = 0; done_cnt = 0; done_cyc = -1;
        start = 1'b1; addr = 32'h9000; total_len = 32'd0; max_length = 32'd4;
        s = cyc;
        step();
        start = 1'b0;
        check("zero_done_n1", done_cyc, s + 1);
        check("zero_busy", busy, 1'b0);
        repeat (4) step();
        check("zero_no_ar", ar_count, 0);
        check("zero_done_pulse", done_cnt, 1);

        // reset while the skid buffer holds two beats
        load_model('{32'h0000_8000, 32'd16, 32'd16, 0, 0, 100, 0, 1, 1'b0});
        start = 1'b1; addr = 32'h8000; total_len = 32'd16; max_length = 32'd16;
        step();
        start = 1'b0;
        n = 0;
        while (occ < 2 && n < 100) begin
            step();
            n++;
        end
        repeat (2) step();
        check("full_occ", occ, 2);
        check("full_rready", axi_rready, 1'b0);
        check("full_tvalid", axis_tvalid, 1'b1);
        axi_aresetn = 1'b0;
        #1;
        check_reset("mid");
        exp_ar_q.delete();
        exp_beat_q.delete();
        r_active = 0; r_hold = 0; occ = 0; exp_id = 4'd0;
        gap_pend = 0; prev_ar_wait = 0;
        axi_rvalid = 1'b1;
        axi_rdata  = 128'hDEAD;
        repeat (2) @(negedge axi_aclk);
        axi_aresetn = 1'b1;
        stale_rdy = 0;
        repeat (3) begin
            @(negedge axi_aclk);
            if (axi_rready) stale_rdy++;
        end
        check("stale_r_blocked", stale_rdy, 0);
        axi_rvalid = 1'b0;
        run_vec(9);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
